// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: bus width, wait-counter width and the
// memory-data-register load FSM state encoding.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mdr_state_t;

endpackage

// File: rtl/wait_counter.sv
// Counts WAIT cycles of a memory read and flags the last cycle before the
// read is abandoned. Saturates at the limit so it can never wrap.
module wait_counter
    import cpu_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic en,
    output logic limit_hit
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    assign limit_hit = (cnt == TERM);

    always_ff @(posedge clock) begin
        if (clear || start) begin
            cnt <= '0;
        end else if (en && !limit_hit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mdr_mem_if.sv
// Memory data register with a bus/memory load sequencer and read timeout.
//
//   state | meaning
//   IDLE  | waiting for mdr_in; the only state that accepts a load
//   WAIT  | memory read outstanding, mem_req held high
//   DONE  | one-cycle completion, done pulsed
module mdr_mem_if
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_mux_out,
    input  logic              mdr_in,
    input  logic              read,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    mdr_state_t state;
    logic       limit_hit;
    logic       cnt_start;
    logic       cnt_en;

    assign mem_req = (state == WAIT);
    assign done    = (state == DONE);
    assign busy    = (state != IDLE);

    assign cnt_start = (state == IDLE) && mdr_in && read;
    // Only non-ready WAIT cycles count toward the timeout.
    assign cnt_en    = (state == WAIT) && !mem_ready;

    wait_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_counter (
        .clock     (clock),
        .clear     (clear),
        .start     (cnt_start),
        .en        (cnt_en),
        .limit_hit (limit_hit)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            mdr_out     <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mdr_in) begin
                        timeout_err <= 1'b0;
                        if (read) begin
                            state <= WAIT;
                        end else begin
                            mdr_out <= bus_mux_out;
                            state   <= DONE;
                        end
                    end
                end
                WAIT: begin
                    // Ready wins over a timeout landing on the same edge.
                    if (mem_ready) begin
                        mdr_out <= mem_rdata;
                        state   <= DONE;
                    end else if (limit_hit) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_mem_if.sv
// Randomized scoreboard bench for mdr_mem_if: the driver predicts each load's
// outcome and queues it; a monitor pops and compares on done or timeout.
module tb_mdr_mem_if;
    import cpu_pkg::*;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] bus_mux_out;
    logic        mdr_in;
    logic        read;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic [31:0] mdr_out;
    logic        busy;
    logic        done;
    logic        timeout_err;

    always #5 clock = ~clock;

    mdr_mem_if #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .bus_mux_out (bus_mux_out),
        .mdr_in      (mdr_in),
        .read        (read),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mdr_out     (mdr_out),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    typedef struct {
        bit          is_done;
        logic [31:0] data;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    logic [31:0] model_mdr;
    logic        prev_terr = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an outcome is a done pulse or a fresh timeout_err rise.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = expq.pop_front();
                check("outcome_kind_done", 32'(mon_e.is_done), 32'd1);
                check("done_data", mdr_out, mon_e.data);
                check("done_terr", 32'(timeout_err), 32'd0);
                check("done_busy", 32'(busy), 32'd1);
            end
        end
        if (timeout_err === 1'b1 && prev_terr === 1'b0) begin
            if (expq.size() == 0) begin
                check("unexpected_timeout", 32'd1, 32'd0);
            end else begin
                mon_e = expq.pop_front();
                check("outcome_kind_timeout", 32'(mon_e.is_done), 32'd0);
                check("timeout_data", mdr_out, mon_e.data);
                check("timeout_busy", 32'(busy), 32'd0);
                check("timeout_done", 32'(done), 32'd0);
            end
        end
        prev_terr = timeout_err;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_bus(input logic [31:0] data);
        bus_mux_out = data;
        mdr_in      = 1'b1;
        read        = 1'b0;
        expq.push_back('{is_done: 1'b1, data: data});
        model_mdr = data;
        step();
        mdr_in      = 1'b0;
        bus_mux_out = $urandom;
        check("bus_latency_data", mdr_out, data);
        check("bus_done_hi", 32'(done), 32'd1);
        check("bus_busy_hi", 32'(busy), 32'd1);
        step();
        check("bus_done_lo", 32'(done), 32'd0);
        check("bus_busy_lo", 32'(busy), 32'd0);
    endtask

    // k = WAIT cycle (1-based) in which mem_ready rises; k > T means never.
    task automatic do_mem(input logic [31:0] data, input int k, input bit noise);
        int reqs = 0;
        int exp_reqs;
        bit ok = (k <= T);
        exp_reqs = ok ? k : T;
        if (ok) begin
            expq.push_back('{is_done: 1'b1, data: data});
            model_mdr = data;
        end else begin
            expq.push_back('{is_done: 1'b0, data: model_mdr});
        end
        mdr_in = 1'b1;
        read   = 1'b1;
        step();
        mdr_in = 1'b0;
        for (int c = 1; c <= T; c++) begin
            if (mem_req === 1'b1) reqs++;
            mem_ready = (c == k);
            mem_rdata = (c == k) ? data : $urandom;
            if (noise) begin
                mdr_in      = 1'($urandom);
                read        = 1'($urandom);
                bus_mux_out = $urandom;
            end
            step();
            if (c == k) break;
        end
        mdr_in    = 1'b0;
        mem_ready = 1'b0;
        check("mem_req_cycles", 32'(reqs), 32'(exp_reqs));
        if (ok) begin
            if (noise) begin
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
                mdr_in    = 1'($urandom);
                read      = 1'($urandom);
            end
            step();
            mem_ready = 1'b0;
            mdr_in    = 1'b0;
        end
        check("mem_end_busy", 32'(busy), 32'd0);
        check("mem_end_req", 32'(mem_req), 32'd0);
        check("mem_end_mdr", mdr_out, model_mdr);
        check("mem_end_terr", 32'(timeout_err), 32'(!ok));
    endtask

    initial begin
        clear       = 1'b1;
        mdr_in      = 1'b1;
        read        = 1'b0;
        bus_mux_out = 32'hCAFE_F00D;
        mem_rdata   = 32'h0;
        mem_ready   = 1'b1;
        model_mdr   = 32'h0;
        step();
        check("rst_mdr", mdr_out, 32'h0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        step();
        clear     = 1'b0;
        mdr_in    = 1'b0;
        mem_ready = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_mdr", mdr_out, 32'h0);

        do_bus(32'hDEAD_BEEF);
        do_mem(32'h1234_5678, 4, 1'b0);
        do_mem(32'h0BAD_0BAD, T + 1, 1'b0);
        do_mem(32'hA5A5_A5A5, T, 1'b0);
        bus_mux_out = 32'hFFFF_FFFF;
        do_mem(32'h600D_CAFE, 3, 1'b1);

        // Abandon a read with clear during its second WAIT cycle.
        do_bus(32'h0000_0055);
        mdr_in = 1'b1;
        read   = 1'b1;
        step();
        mdr_in = 1'b0;
        step();
        clear     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_7777;
        step();
        clear     = 1'b0;
        model_mdr = 32'h0;
        check("clr_mdr", mdr_out, 32'h0);
        check("clr_req", 32'(mem_req), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_terr", 32'(timeout_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            mem_rdata = $urandom;
            step();
            check("clr_late_ready_mdr", mdr_out, 32'h0);
            check("clr_late_ready_busy", 32'(busy), 32'd0);
        end
        mem_ready = 1'b0;

        for (int n = 0; n < 200; n++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
                read      = 1'($urandom);
                step();
                check("idle_mdr_hold", mdr_out, model_mdr);
            end
            mem_ready = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                do_bus($urandom);
            end else begin
                do_mem($urandom, $urandom_range(1, T + 1), 1'($urandom));
            end
        end

        step();
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
